ddr_wr_burst_master: RTL and testbench
======================================

# ddr_wr_burst_master

Sits between the line write buffer and the DDR controller's AXI write port, in the `ddr_clk` domain. It accepts one line-write request (address plus beat count) over the `ddr_wreq`/`ddr_wrdy`/`ddr_wdata_req`/`ddr_wdone` handshake and splits it into AXI4 INCR bursts of at most `MAX_BURST` beats. Each beat is pulled from the upstream buffer only when the AXI W channel can absorb it, and the block pulses `ddr_wdone` once the whole line has been acknowledged.

## Interface
Parameters:
- `ADDR_WIDTH`, 27: DDR word address width (DQ-word units, same as upstream).
- `DQ_WIDTH`, 16: DDR DQ width; beat width is 8*`DQ_WIDTH`.
- `LEN_WIDTH`, 16: request length width, in beats.
- `MAX_BURST`, 16: maximum beats per AXI burst; range 1..256.

Ports:
- `ddr_clk`  in  1  sole clock.
- `ddr_rstn`  in  1  asynchronous, active-low reset.
- `ddr_wreq`  in  1  line-write request; held high until the first `ddr_wdata_req`.
- `ddr_waddr`  in  `ADDR_WIDTH`  start address; sampled when the request is accepted.
- `ddr_wr_len`  in  `LEN_WIDTH`  beat count; sampled when the request is accepted.
- `ddr_wrdy`  out  1  block idle, can accept a request.
- `ddr_wdata_req`  out  1  consume one beat this cycle.
- `ddr_wdata`  in  8*`DQ_WIDTH`  beat data; valid in the same cycle as `ddr_wdata_req`.
- `ddr_wdone`  out  1  one-cycle pulse: line fully written.
- `axi_awaddr`  out  `ADDR_WIDTH`  burst address (DQ-word units).
- `axi_awlen`  out  8  beats−1.
- `axi_awvalid` / `axi_awready`  out / in  1  address handshake.
- `axi_wdata`  out  8*`DQ_WIDTH`  write data.
- `axi_wlast`  out  1  last beat of the burst.
- `axi_wvalid` / `axi_wready`  out / in  1  data handshake.
- `axi_bvalid` / `axi_bready`  in / out  1  response handshake.
- `axi_bresp`  in  2  write response.
- `wr_err`  out  1  sticky: some `bresp` ≠ 0; cleared only by reset.

## Operation
States: IDLE → AW → W → B → AW or DONE → IDLE.
- **IDLE**
  - `ddr_wrdy`=1.
  - On `ddr_wreq`: latch `addr`←`ddr_waddr` and `rem`←`ddr_wr_len`; `ddr_wrdy`→0.
  - If `ddr_wr_len`=0, go to DONE. Otherwise go to AW.
- **AW**
  - `blen` = min(`rem`, `MAX_BURST`).
  - `axi_awaddr`=`addr`, `axi_awlen`=`blen`−1.
  - `axi_awvalid` stays high until `axi_awready`, then go to W.
- **W**
  - `ddr_wdata_req` (combinational) = beats requested in this burst < `blen` AND FIFO occupancy after this cycle's pop < 2.
  - The requested beat is pushed into a 2-entry FIFO in the same cycle.
  - `axi_wvalid` = FIFO non-empty. `axi_wlast` = the head beat's burst index equals `blen`−1.
  - After the `wlast` handshake, go to B.
- **B**
  - `axi_bready`=1.
  - On `axi_bvalid`: if `bresp`≠0, set `wr_err`.
  - Update `addr`+=8·`blen` and `rem`−=`blen`.
  - If `rem`=0, go to DONE; otherwise go to AW.
- **DONE**
  - `ddr_wdone`=1 for one cycle, then go to IDLE.

Width and boundary rules:
- Address arithmetic wraps modulo 2^`ADDR_WIDTH`.
- A `ddr_wreq` arriving outside IDLE is ignored; the upstream must wait for `ddr_wrdy`.
- Asserting reset mid-line aborts the line: state→IDLE, FIFO emptied, no `ddr_wdone` pulse.

## Timing
- Reset values:
  - `ddr_wrdy`=0; it rises in the first cycle after reset release.
  - `ddr_wdata_req`, `ddr_wdone`, `axi_awvalid`, `axi_wvalid`, `axi_wlast`, `axi_bready` and `wr_err` are all 0.
  - `axi_awaddr`=0, `axi_awlen`=0, `axi_wdata`=0.
- All outputs are registered except `ddr_wdata_req`, `axi_wvalid`, `axi_wlast` and `axi_wdata`, which come from the FIFO head and its counters.
- Request acceptance → `axi_awvalid`: 1 cycle.
- AW handshake → first `ddr_wdata_req`: 1 cycle.
- `ddr_wdata_req` → the same beat on `axi_wdata` with `axi_wvalid`: 1 cycle.
- With `axi_wready` held at 1, beats stream at 1 per cycle with no bubbles.
- Final `axi_bvalid` → `ddr_wdone`: 1 cycle. `ddr_wdone` → `ddr_wrdy`: 1 cycle.
- `ddr_wdata_req` never asserts while the FIFO would overflow. The total number of `ddr_wdata_req` cycles per line equals `ddr_wr_len` exactly.

## Structure
- **Shared package:** state enum, `BEAT_ADDR_INC` = 8, beat width 8*`DQ_WIDTH`, AXI `bresp` OKAY code.
- **Sub-module `wr_beat_fifo`:** 2-entry synchronous FIFO (data + last flag) with push/pop/count. It uses the same clock and async reset as the top.
- **Top module:** FSM, `rem`/`addr`/`blen` counters, request counter, pop counter.

## Test plan
- **Nominal split:** `ddr_waddr`=0x1000, `ddr_wr_len`=160, `MAX_BURST`=16, ready signals held at 1.
  - 10 bursts with `awaddr` 0x1000, 0x1080, … 0x1480, `awlen`=15 each.
  - 160 `ddr_wdata_req` cycles.
  - `ddr_wdone` 1 cycle after the 10th `bvalid`.
- **Short tail:** `ddr_wr_len`=37.
  - Bursts of 16, 16, 5 beats; last `awlen`=4, last `awaddr`=base+0x100.
  - `wlast` on beats 16, 32, 37.
- **Backpressure:** `axi_wready` toggles 1010…
  - FIFO never exceeds 2 entries; no beat is lost or duplicated (data = incrementing pattern, checked in order).
  - `ddr_wdata_req` count = 160.
- **Zero length:** `ddr_wr_len`=0.
  - No AW/W traffic.
  - `ddr_wdone` 2 cycles after acceptance.
- **Error and reset:**
  - `bresp`=2 on burst 3 → `wr_err`=1 and stays 1; the line still completes.
  - Reset asserted mid-burst 5 → all outputs return to their reset values asynchronously, and no `ddr_wdone` pulse occurs.

Source files
------------

// File: rtl/ddr_wr_burst_master_pkg.sv
// Shared types and constants for the DDR line-write burst master.
package ddr_wr_burst_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_e;

  localparam int unsigned BEAT_ADDR_INC = 8;
  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

  function automatic int unsigned beat_width(input int unsigned dq_width);
    return 8 * dq_width;
  endfunction

endpackage

// File: rtl/wr_beat_fifo.sv
// Two-entry beat FIFO (data plus burst-last flag) between the upstream pull and AXI W.
module wr_beat_fifo #(
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_last_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] data_q [2];
  logic [1:0]        last_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  // Storage is cleared on reset so the head reads as zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign head_data_o = data_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/ddr_wr_burst_master.sv
// Splits one upstream line write into AXI4 INCR bursts of at most MAX_BURST beats.
module ddr_wr_burst_master #(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DQ_WIDTH   = 16,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rstn,
  input  logic                    ddr_wreq,
  input  logic [ADDR_WIDTH-1:0]   ddr_waddr,
  input  logic [LEN_WIDTH-1:0]    ddr_wr_len,
  output logic                    ddr_wrdy,
  output logic                    ddr_wdata_req,
  input  logic [8*DQ_WIDTH-1:0]   ddr_wdata,
  output logic                    ddr_wdone,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [8*DQ_WIDTH-1:0]   axi_wdata,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  input  logic [1:0]              axi_bresp,
  output logic                    wr_err
);

  import ddr_wr_burst_master_pkg::*;

  localparam int unsigned BEAT_W = beat_width(DQ_WIDTH);
  localparam int unsigned BLEN_W = $clog2(MAX_BURST + 1);

  function automatic logic [BLEN_W-1:0] burst_len(input logic [LEN_WIDTH-1:0] rem);
    if (32'(rem) > MAX_BURST) return BLEN_W'(MAX_BURST);
    return BLEN_W'(rem);
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [BLEN_W-1:0]     blen_q, blen_d;
  logic [BLEN_W-1:0]     req_cnt_q, req_cnt_d;
  logic [7:0]            awlen_q, awlen_d;
  logic                  awvalid_q, awvalid_d;
  logic                  bready_q, bready_d;
  logic                  wrdy_q, wrdy_d;
  logic                  wdone_q, wdone_d;
  logic                  wr_err_q, wr_err_d;
  logic [BLEN_W-1:0]     nblen;

  logic                  fifo_pop;
  logic                  fifo_push_last;
  logic                  head_last;
  logic [1:0]            fifo_count;
  logic [1:0]            occ_after;

  wr_beat_fifo #(
    .DATA_W (BEAT_W)
  ) u_fifo (
    .clk         (ddr_clk),
    .rst_n       (ddr_rstn),
    .push_i      (ddr_wdata_req),
    .push_data_i (ddr_wdata),
    .push_last_i (fifo_push_last),
    .pop_i       (fifo_pop),
    .head_data_o (axi_wdata),
    .head_last_o (head_last),
    .count_o     (fifo_count)
  );

  // Pull a beat only when the FIFO will still have room after this cycle's pop.
  assign axi_wvalid     = (fifo_count != 2'd0);
  assign axi_wlast      = axi_wvalid & head_last;
  assign fifo_pop       = axi_wvalid & axi_wready;
  assign occ_after      = fifo_count - 2'(fifo_pop);
  assign fifo_push_last = (req_cnt_q == blen_q - BLEN_W'(1));
  assign ddr_wdata_req  = (state_q == ST_W) && (req_cnt_q < blen_q) && (occ_after < 2'd2);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    blen_d    = blen_q;
    req_cnt_d = req_cnt_q;
    awlen_d   = awlen_q;
    awvalid_d = awvalid_q;
    bready_d  = bready_q;
    wdone_d   = 1'b0;
    wr_err_d  = wr_err_q;
    nblen     = '0;

    case (state_q)
      ST_IDLE: begin
        if (ddr_wreq && wrdy_q) begin
          addr_d = ddr_waddr;
          rem_d  = ddr_wr_len;
          if (ddr_wr_len == '0) begin
            state_d = ST_DONE;
          end else begin
            nblen     = burst_len(ddr_wr_len);
            blen_d    = nblen;
            awlen_d   = 8'(nblen - BLEN_W'(1));
            awvalid_d = 1'b1;
            state_d   = ST_AW;
          end
        end
      end
      ST_AW: begin
        if (axi_awready) begin
          awvalid_d = 1'b0;
          req_cnt_d = '0;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (ddr_wdata_req) begin
          req_cnt_d = req_cnt_q + BLEN_W'(1);
        end
        if (fifo_pop && head_last) begin
          bready_d = 1'b1;
          state_d  = ST_B;
        end
      end
      ST_B: begin
        if (axi_bvalid) begin
          bready_d = 1'b0;
          if (axi_bresp != AXI_RESP_OKAY) wr_err_d = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(BEAT_ADDR_INC * 32'(blen_q));
          rem_d  = rem_q - LEN_WIDTH'(blen_q);
          if (rem_d == '0) begin
            wdone_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            nblen     = burst_len(rem_d);
            blen_d    = nblen;
            awlen_d   = 8'(nblen - BLEN_W'(1));
            awvalid_d = 1'b1;
            state_d   = ST_AW;
          end
        end
      end
      ST_DONE: begin
        // Zero-length lines arrive here without the pulse; emit it before leaving.
        if (wdone_q) begin
          state_d = ST_IDLE;
        end else begin
          wdone_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wrdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      blen_q    <= '0;
      req_cnt_q <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      wrdy_q    <= 1'b0;
      wdone_q   <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      blen_q    <= blen_d;
      req_cnt_q <= req_cnt_d;
      awlen_q   <= awlen_d;
      awvalid_q <= awvalid_d;
      bready_q  <= bready_d;
      wrdy_q    <= wrdy_d;
      wdone_q   <= wdone_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign ddr_wrdy    = wrdy_q;
  assign ddr_wdone   = wdone_q;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awvalid = awvalid_q;
  assign axi_bready  = bready_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_ddr_wr_burst_master.sv
// Directed bench for ddr_wr_burst_master: burst split, tail, backpressure, zero length, error, reset.
module tb_ddr_wr_burst_master;

  localparam int AW = 27;
  localparam int LW = 16;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ddr_wreq = 1'b0;
  logic [AW-1:0] ddr_waddr = '0;
  logic [LW-1:0] ddr_wr_len = '0;
  logic          ddr_wrdy, ddr_wdata_req, ddr_wdone;
  logic [BW-1:0] ddr_wdata;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic          axi_awvalid;
  logic          axi_awready = 1'b1;
  logic [BW-1:0] axi_wdata;
  logic          axi_wlast, axi_wvalid;
  logic          axi_wready = 1'b1;
  logic          axi_bvalid = 1'b0;
  logic          axi_bready;
  logic [1:0]    axi_bresp = 2'b00;
  logic          wr_err;

  int checks = 0;
  int errors = 0;

  // monitor / slave state
  int cyc = 0, req_total = 0, aw_total = 0, w_total = 0, wl_total = 0, b_total = 0;
  int done_total = 0, data_err = 0, occ = 0, max_occ = 0, done_cyc = 0, b_cyc = 0;
  int req_since_aw = 0, w_since_aw = 0;
  int err_at = -1;
  bit bp_mode = 1'b0;
  int unsigned src_idx = 32'h100, w_idx = 32'h100;
  logic req_prev = 1'b0, wl_prev = 1'b0, b_prev = 1'b0, awv_prev = 1'b0, pop;
  int aw_cyc_log[64], awv_rise_log[64], fr_cyc_log[64], fw_cyc_log[64];
  int wl_cyc_log[64], wl_pos_log[64];
  logic [AW-1:0] aw_addr_log[64];
  logic [7:0]    aw_len_log[64];

  always #5 clk = ~clk;

  assign ddr_wdata = {4{src_idx}};

  ddr_wr_burst_master #(
    .ADDR_WIDTH (AW),
    .DQ_WIDTH   (16),
    .LEN_WIDTH  (LW),
    .MAX_BURST  (16)
  ) dut (
    .ddr_clk       (clk),
    .ddr_rstn      (rst_n),
    .ddr_wreq      (ddr_wreq),
    .ddr_waddr     (ddr_waddr),
    .ddr_wr_len    (ddr_wr_len),
    .ddr_wrdy      (ddr_wrdy),
    .ddr_wdata_req (ddr_wdata_req),
    .ddr_wdata     (ddr_wdata),
    .ddr_wdone     (ddr_wdone),
    .axi_awaddr    (axi_awaddr),
    .axi_awlen     (axi_awlen),
    .axi_awvalid   (axi_awvalid),
    .axi_awready   (axi_awready),
    .axi_wdata     (axi_wdata),
    .axi_wlast     (axi_wlast),
    .axi_wvalid    (axi_wvalid),
    .axi_wready    (axi_wready),
    .axi_bvalid    (axi_bvalid),
    .axi_bready    (axi_bready),
    .axi_bresp     (axi_bresp),
    .wr_err        (wr_err)
  );

  // AXI slave and traffic logger: drive at negedge, sample 1 time unit later.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (req_prev) src_idx = src_idx + 1;
    if (b_prev) axi_bvalid = 1'b0;
    if (wl_prev) begin
      axi_bvalid = 1'b1;
      axi_bresp  = (b_total == err_at) ? 2'd2 : 2'd0;
    end
    axi_wready = bp_mode ? ((cyc % 2) == 1) : 1'b1;
    if (!rst_n) begin
      axi_bvalid = 1'b0;
      occ = 0;
    end
    #1;
    if (!rst_n) begin
      req_prev = 1'b0; wl_prev = 1'b0; b_prev = 1'b0; awv_prev = 1'b0;
      w_idx = src_idx;
    end else begin
      req_prev = ddr_wdata_req;
      if (ddr_wdata_req) begin
        if (req_since_aw == 0 && aw_total > 0) fr_cyc_log[aw_total-1] = cyc;
        req_since_aw = req_since_aw + 1;
        req_total = req_total + 1;
      end
      if (axi_awvalid && !awv_prev) awv_rise_log[aw_total] = cyc;
      awv_prev = axi_awvalid;
      if (axi_awvalid && axi_awready) begin
        aw_cyc_log[aw_total]  = cyc;
        aw_addr_log[aw_total] = axi_awaddr;
        aw_len_log[aw_total]  = axi_awlen;
        aw_total = aw_total + 1;
        req_since_aw = 0;
        w_since_aw = 0;
      end
      pop = axi_wvalid && axi_wready;
      wl_prev = pop && axi_wlast;
      if (pop) begin
        if (axi_wdata !== {4{w_idx}}) data_err = data_err + 1;
        if (w_since_aw == 0 && aw_total > 0) fw_cyc_log[aw_total-1] = cyc;
        w_since_aw = w_since_aw + 1;
        w_idx = w_idx + 1;
        w_total = w_total + 1;
        if (axi_wlast) begin
          wl_cyc_log[wl_total] = cyc;
          wl_pos_log[wl_total] = w_total;
          wl_total = wl_total + 1;
        end
      end
      occ = occ + int'(ddr_wdata_req) - int'(pop);
      if (occ > max_occ) max_occ = occ;
      if (occ < 0) data_err = data_err + 1;
      b_prev = axi_bvalid && axi_bready;
      if (b_prev) begin
        b_total = b_total + 1;
        b_cyc = cyc;
      end
      if (ddr_wdone) begin
        done_total = done_total + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wrdy"},    ddr_wrdy, 0);
    check({tag, "_wreq"},    ddr_wdata_req, 0);
    check({tag, "_wdone"},   ddr_wdone, 0);
    check({tag, "_awvalid"}, axi_awvalid, 0);
    check({tag, "_wvalid"},  axi_wvalid, 0);
    check({tag, "_wlast"},   axi_wlast, 0);
    check({tag, "_bready"},  axi_bready, 0);
    check({tag, "_wr_err"},  wr_err, 0);
    check({tag, "_awaddr"},  axi_awaddr, 0);
    check({tag, "_awlen"},   axi_awlen, 0);
    check({tag, "_wdata"},   axi_wdata, 0);
  endtask

  task automatic start_line(input logic [AW-1:0] a, input logic [LW-1:0] len, output int acc);
    int t;
    t = 0;
    while (!ddr_wrdy && t < 100) begin
      step();
      t++;
    end
    check("wrdy_before_req", ddr_wrdy, 1);
    ddr_wreq = 1'b1;
    ddr_waddr = a;
    ddr_wr_len = len;
    acc = cyc;
    step();
    ddr_wreq = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int t;
    t = 0;
    while (done_total == base && t < 2000) begin
      step();
      t++;
    end
    check("wdone_seen", done_total - base, 1);
  endtask

  initial begin
    int acc, aw_b, req_b, w_b, wl_b, b_b, done_b, derr_b, t;

    #1 rst_n = 1'b0;
    step(); step(); step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1 check("wrdy_at_release", ddr_wrdy, 0);
    step();
    check("wrdy_after_release", ddr_wrdy, 1);

    // Nominal: 160 beats at 0x1000 -> 10 bursts of 16.
    aw_b = aw_total; req_b = req_total; w_b = w_total; wl_b = wl_total; b_b = b_total;
    done_b = done_total; derr_b = data_err;
    start_line(27'h1000, 16'd160, acc);
    check("nom_wrdy_low", ddr_wrdy, 0);
    wait_done(done_b);
    check("nom_done_lat", done_cyc - b_cyc, 1);
    check("nom_req_cnt", req_total - req_b, 160);
    check("nom_aw_cnt", aw_total - aw_b, 10);
    check("nom_b_cnt", b_total - b_b, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("nom_awaddr%0d", i), aw_addr_log[aw_b+i], 27'h1000 + 27'(i * 27'h80));
      check($sformatf("nom_awlen%0d", i), aw_len_log[aw_b+i], 15);
    end
    check("nom_wlast_cnt", wl_total - wl_b, 10);
    check("nom_data", data_err - derr_b, 0);
    check("nom_acc_to_awvalid", awv_rise_log[aw_b] - acc, 1);
    check("nom_aw_to_req", fr_cyc_log[aw_b] - aw_cyc_log[aw_b], 1);
    check("nom_req_to_w", fw_cyc_log[aw_b] - fr_cyc_log[aw_b], 1);
    check("nom_no_bubble", wl_cyc_log[wl_b] - fw_cyc_log[aw_b], 15);
    step();
    check("nom_wrdy_after_done", ddr_wrdy, 1);
    check("nom_wdone_one_cycle", ddr_wdone, 0);

    // Short tail: 37 beats -> 16, 16, 5.
    aw_b = aw_total; req_b = req_total; w_b = w_total; wl_b = wl_total;
    done_b = done_total; derr_b = data_err;
    start_line(27'h2000, 16'd37, acc);
    wait_done(done_b);
    check("tail_aw_cnt", aw_total - aw_b, 3);
    check("tail_awlen0", aw_len_log[aw_b], 15);
    check("tail_last_awaddr", aw_addr_log[aw_b+2], 27'h2100);
    check("tail_last_awlen", aw_len_log[aw_b+2], 4);
    check("tail_wlast_a", wl_pos_log[wl_b] - w_b, 16);
    check("tail_wlast_b", wl_pos_log[wl_b+1] - w_b, 32);
    check("tail_wlast_c", wl_pos_log[wl_b+2] - w_b, 37);
    check("tail_req_cnt", req_total - req_b, 37);
    check("tail_data", data_err - derr_b, 0);

    // Backpressure: wready toggles every cycle.
    bp_mode = 1'b1;
    req_b = req_total; w_b = w_total; done_b = done_total; derr_b = data_err; aw_b = aw_total;
    start_line(27'h4000, 16'd160, acc);
    wait_done(done_b);
    bp_mode = 1'b0;
    check("bp_req_cnt", req_total - req_b, 160);
    check("bp_w_cnt", w_total - w_b, 160);
    check("bp_aw_cnt", aw_total - aw_b, 10);
    check("bp_data", data_err - derr_b, 0);
    check("bp_max_occ_le2", max_occ <= 2, 1);

    // Zero length: no traffic, wdone two cycles after acceptance.
    aw_b = aw_total; req_b = req_total; w_b = w_total; done_b = done_total;
    start_line(27'h3000, 16'd0, acc);
    wait_done(done_b);
    check("zero_done_lat", done_cyc - acc, 2);
    check("zero_aw_cnt", aw_total - aw_b, 0);
    check("zero_req_cnt", req_total - req_b, 0);
    check("zero_w_cnt", w_total - w_b, 0);
    step();
    check("zero_wrdy_after", ddr_wrdy, 1);

    // Error response on the third burst of a 64-beat line.
    check("err_clear_before", wr_err, 0);
    aw_b = aw_total; b_b = b_total; done_b = done_total; derr_b = data_err;
    err_at = b_total + 2;
    start_line(27'h5000, 16'd64, acc);
    t = 0;
    while (b_total < b_b + 2 && t < 2000) begin
      step();
      t++;
    end
    check("err_clear_after_b2", wr_err, 0);
    wait_done(done_b);
    check("err_set", wr_err, 1);
    check("err_aw_cnt", aw_total - aw_b, 4);
    check("err_data", data_err - derr_b, 0);
    step(); step(); step();
    check("err_sticky", wr_err, 1);
    err_at = -1;

    // Reset in the middle of burst 5.
    w_b = w_total; done_b = done_total;
    start_line(27'h6000, 16'd160, acc);
    t = 0;
    while (w_total < w_b + 67 && t < 2000) begin
      step();
      t++;
    end
    check("rst_mid_reached", w_total - w_b, 67);
    check("rst_mid_wvalid_busy", axi_bready, 0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    step(); step(); step();
    check("rst_mid_no_done", done_total - done_b, 0);
    rst_n = 1'b1;
    #1 check("rst_mid_wrdy_release", ddr_wrdy, 0);
    step();
    check("rst_mid_wrdy_up", ddr_wrdy, 1);
    step(); step(); step();
    check("rst_mid_no_done_after", done_total - done_b, 0);
    check("rst_mid_awvalid_idle", axi_awvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
